// File: rtl/toggle_pulse_gen_pkg.sv
// Shared encodings for the button-to-toggle front end.
// FSM state values and edge-select codes live here so top and bench agree.
// cnt_width gives the qualify counter width for a given debounce length.
package toggle_pulse_gen_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Counter must hold 0..cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/toggle_pulse_gen_sync_chain.sv
// Multi-flop synchronizer for the asynchronous button input.
// Latency: STAGES cycles from d to q.
// No flow control; samples every clock.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw input through the chain; clears to 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/toggle_pulse_gen.sv
// Turns a bouncy push-button into a debounced level and a one-cycle toggle request.
// Latency: SYNC_STAGES+1+DEBOUNCE_CYCLES clocks from a stable input change to level/t_pulse.
// No backpressure; en only masks t_pulse, the FSM keeps tracking the input.
module toggle_pulse_gen
  import toggle_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_SEL        = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic en,
  output logic t_pulse,
  output logic level,
  output logic busy
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic PULSE_ON_RISE = (EDGE_SEL != EDGE_FALL);
  localparam logic PULSE_ON_FALL = (EDGE_SEL != EDGE_RISE);

  // Reject illegal configurations while elaborating rather than building a broken block.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("toggle_pulse_gen: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("toggle_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
  end
  if (EDGE_SEL < 0 || EDGE_SEL > 2) begin : g_bad_edge
    $error("toggle_pulse_gen: EDGE_SEL must be 0, 1 or 2");
  end

  logic          btn_s;
  state_t        state;
  logic [CW-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing samples; any disagreement falls back to the stable state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOW;
      cnt     <= '0;
      t_pulse <= 1'b0;
      level   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      t_pulse <= 1'b0;
      case (state)
        S_LOW: begin
          if (btn_s) begin
            state <= S_RISE;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        S_RISE: begin
          if (!btn_s) begin
            state <= S_LOW;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_HIGH;
            level   <= 1'b1;
            t_pulse <= en & PULSE_ON_RISE;
            busy    <= 1'b0;
          end else begin
            cnt  <= cnt + CW'(1);
            busy <= 1'b1;
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state <= S_FALL;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        S_FALL: begin
          if (btn_s) begin
            state <= S_HIGH;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_LOW;
            level   <= 1'b0;
            t_pulse <= en & PULSE_ON_FALL;
            busy    <= 1'b0;
          end else begin
            cnt  <= cnt + CW'(1);
            busy <= 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
